// File: rtl/ins_mem_responder_pkg.sv
// ins_mem_responder_pkg: shared bus width, NOP fill word and byte-enable merge helper.
`ifndef size_X_LEN
`define size_X_LEN 32
`endif
package ins_mem_responder_pkg;
   localparam int X_LEN = `size_X_LEN;
   localparam logic [X_LEN-1:0] NOP = 32'h00000013;
   function automatic logic [X_LEN-1:0] be_merge(input logic [X_LEN-1:0] old_w, new_w, input logic [3:0] be);
      logic [X_LEN-1:0] r;
      r = old_w;
      for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = new_w[8*k +: 8];
      return r;
   endfunction
endpackage

// File: rtl/ins_mem_resp_pipe.sv
// ins_mem_resp_pipe: LAT-stage {valid, data} response shift pipeline with sync active-low clear.
module ins_mem_resp_pipe #(
   parameter int LAT = 1,
   parameter int W   = 32
)(
   input  logic         clk,
   input  logic         reset,
   input  logic         i_valid,
   input  logic [W-1:0] i_data,
   output logic         o_valid,
   output logic [W-1:0] o_data
);
   logic [LAT-1:0] r_valid;
   logic [W-1:0]   r_data [LAT];
   always_ff @(posedge clk) begin
      if (!reset) r_valid <= '0;
      else begin
         r_valid[0] <= i_valid;
         for (int i = 1; i < LAT; i++) r_valid[i] <= r_valid[i-1];
      end
      r_data[0] <= i_data;
      for (int i = 1; i < LAT; i++) r_data[i] <= r_data[i-1];
   end
   assign o_valid = r_valid[LAT-1];
   assign o_data  = o_valid ? r_data[LAT-1] : '0;
endmodule

// File: rtl/ins_mem_responder.sv
// ins_mem_responder: req/gnt/rvalid memory responder with fixed read latency and outstanding limit.
// Optional periodic grant denial via INS_MEM_RESPONDER_GNT_STALL_EN.
module ins_mem_responder
   import ins_mem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS      = 1024,
   parameter int READ_LATENCY     = 1,
   parameter int MAX_OUTSTANDING  = 2,
   parameter int GNT_STALL_PERIOD = 4
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   data_req_i,
   input  logic [`size_X_LEN-1:0] data_addr_i,
   input  logic                   data_we_i,
   input  logic [3:0]             data_be_i,
   input  logic [`size_X_LEN-1:0] data_wdata_i,
   output logic                   data_gnt_o,
   output logic                   data_rvalid_o,
   output logic [`size_X_LEN-1:0] data_rdata_o,
   input  logic                   load_en_i,
   input  logic [`size_X_LEN-1:0] load_addr_i,
   input  logic [`size_X_LEN-1:0] load_data_i
);
   localparam int IW = $clog2(DEPTH_WORDS);
   logic [X_LEN-1:0] r_mem [DEPTH_WORDS];
   logic [3:0]       r_cnt;
   logic             w_gnt, w_stall_ok, w_rvalid, w_unused;
   logic [IW-1:0]    w_idx, w_load_idx;
   logic [X_LEN-1:0] w_rd;
   assign w_idx      = data_addr_i[IW+1:2];
   assign w_load_idx = load_addr_i[IW+1:2];
   assign w_unused   = ^{data_addr_i[X_LEN-1:IW+2], data_addr_i[1:0], load_addr_i[X_LEN-1:IW+2], load_addr_i[1:0]};
`ifdef INS_MEM_RESPONDER_GNT_STALL_EN
   logic [7:0] r_stall;
   always_ff @(posedge clk)
      if (!reset || r_stall == 8'(GNT_STALL_PERIOD - 1)) r_stall <= '0;
      else r_stall <= r_stall + 8'd1;
   assign w_stall_ok = r_stall != 8'(GNT_STALL_PERIOD - 1);
`else
   assign w_stall_ok = 1'b1 | (GNT_STALL_PERIOD == 0);
`endif
   // a response leaving this cycle frees its slot for a same-cycle grant
   assign w_gnt = data_req_i && ((r_cnt - {3'b0, w_rvalid}) < 4'(MAX_OUTSTANDING)) && w_stall_ok;
   assign w_rd  = data_we_i ? '0 : r_mem[w_idx];
   always_ff @(posedge clk) begin
      if (load_en_i) r_mem[w_load_idx] <= load_data_i;
      if (w_gnt && data_we_i) r_mem[w_idx] <= be_merge(r_mem[w_idx], data_wdata_i, data_be_i);
   end
   always_ff @(posedge clk)
      if (!reset) r_cnt <= '0;
      else r_cnt <= r_cnt + {3'b0, w_gnt} - {3'b0, w_rvalid};
   ins_mem_resp_pipe #(.LAT(READ_LATENCY), .W(X_LEN)) u_pipe (
      .clk     (clk),
      .reset   (reset),
      .i_valid (w_gnt),
      .i_data  (w_rd),
      .o_valid (w_rvalid),
      .o_data  (data_rdata_o)
   );
   assign data_gnt_o    = w_gnt;
   assign data_rvalid_o = w_rvalid;
endmodule

// File: tb/tb_ins_mem_responder.sv
// tb_ins_mem_responder: directed checks on a LAT=1/MO=2 instance and a LAT=3/MO=1 instance.
module tb_ins_mem_responder;
   import ins_mem_responder_pkg::*;
`ifdef INS_MEM_RESPONDER_GNT_STALL_EN
   localparam bit STALL = 1'b1;
`else
   localparam bit STALL = 1'b0;
`endif
   logic        clk = 0, reset = 0;
   logic        req_a = 0, we_a = 0, req_b = 0, load_en = 0;
   logic [3:0]  be_a = 0;
   logic [31:0] addr_a = 0, wdata_a = 0, addr_b = 0, load_addr = 0, load_data = 0;
   logic        gnt_a, rv_a, gnt_b, rv_b, prev_g, exp_g;
   logic [31:0] rd_a, rd_b;
   int          n_chk = 0, n_err = 0, n_g, n_rv;
   always #5 clk = ~clk;
   ins_mem_responder u_a (
      .clk(clk), .reset(reset), .data_req_i(req_a), .data_addr_i(addr_a), .data_we_i(we_a),
      .data_be_i(be_a), .data_wdata_i(wdata_a), .data_gnt_o(gnt_a), .data_rvalid_o(rv_a),
      .data_rdata_o(rd_a), .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data)
   );
   ins_mem_responder #(.READ_LATENCY(3), .MAX_OUTSTANDING(1)) u_b (
      .clk(clk), .reset(reset), .data_req_i(req_b), .data_addr_i(addr_b), .data_we_i(1'b0),
      .data_be_i(4'h0), .data_wdata_i(32'h0), .data_gnt_o(gnt_b), .data_rvalid_o(rv_b),
      .data_rdata_o(rd_b), .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic preload(input logic [31:0] a, input logic [31:0] d);
      load_en = 1; load_addr = a; load_data = d;
      tick;
      load_en = 0;
   endtask
   task automatic bus(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      req_a = r; we_a = w; addr_a = a; wdata_a = d; be_a = be;
   endtask
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
   initial begin
      tick; tick;
      @(negedge clk);
      chk("rst_rvalid_a", rv_a, 0); chk("rst_rdata_a", rd_a, 0); chk("rst_rvalid_b", rv_b, 0);
      preload(32'h0, 32'h00500093); preload(32'h4, 32'h00100113);
      preload(32'h8, NOP); preload(32'h10, 32'h11223344);
      reset = 1;
      // back-to-back reads
      bus(1, 0, 32'h0, 0, 0); @(negedge clk); chk("b2b_gnt0", gnt_a, 1); chk("b2b_rv0", rv_a, 0); tick;
      bus(1, 0, 32'h4, 0, 0); @(negedge clk); chk("b2b_gnt1", gnt_a, 1); chk("b2b_rv1", rv_a, 1); chk("b2b_rd1", rd_a, 32'h00500093); tick;
      bus(0, 0, 0, 0, 0); @(negedge clk); chk("b2b_rv2", rv_a, 1); chk("b2b_rd2", rd_a, 32'h00100113); tick;
      @(negedge clk); chk("b2b_rv3", rv_a, 0); chk("b2b_rd3", rd_a, 0); tick;
      // partial write then read-after-write
      bus(1, 1, 32'h10, 32'hDEADBEEF, 4'b0011); @(negedge clk); chk("wr_gnt", gnt_a, 1); tick;
      bus(1, 0, 32'h10, 0, 0); @(negedge clk); chk("raw_gnt", gnt_a, 1); chk("wr_rv", rv_a, 1); chk("wr_rdata", rd_a, 0); tick;
      bus(0, 0, 0, 0, 0); @(negedge clk); chk("raw_rv", rv_a, 1); chk("raw_rd", rd_a, 32'h1122BEEF); tick;
      // address wrap and ignored low bits
      bus(1, 0, 32'h1000, 0, 0); tick;
      bus(1, 0, 32'h1006, 0, 0); @(negedge clk); chk("wrap_rd", rd_a, 32'h00500093); tick;
      bus(1, 0, 32'h1008, 0, 0); @(negedge clk); chk("lsb_rd", rd_a, 32'h00100113); tick;
      bus(0, 0, 0, 0, 0); @(negedge clk); chk("nop_rd", rd_a, NOP); tick;
      // bus write beats preload to the same word
      load_en = 1; load_addr = 32'h20; load_data = 32'hAAAAAAAA;
      bus(1, 1, 32'h20, 32'h55555555, 4'hF); @(negedge clk); chk("coll_gnt", gnt_a, 1); tick;
      load_en = 0; bus(1, 0, 32'h20, 0, 0); tick;
      bus(0, 0, 0, 0, 0); @(negedge clk); chk("coll_rd", rd_a, 32'h55555555); tick;
      // MAX_OUTSTANDING=1, LAT=3, req held for cycles 0..6
      for (int c = 0; c <= 10; c++) begin
         req_b = (c <= 6); addr_b = 32'h0;
         @(negedge clk);
         chk($sformatf("mo1_gnt%0d", c), gnt_b, (c <= 6) && (c % 3 == 0));
         chk($sformatf("mo1_rv%0d", c), rv_b, c == 3 || c == 6 || c == 9);
         chk($sformatf("mo1_rd%0d", c), rd_b, (c == 3 || c == 6 || c == 9) ? 32'h00500093 : 32'h0);
         tick;
      end
      // reset with responses in flight
      bus(1, 0, 32'h0, 0, 0); req_b = 1; addr_b = 32'h4;
      @(negedge clk); chk("mid_gnt_a0", gnt_a, 1); chk("mid_gnt_b0", gnt_b, 1); tick;
      bus(1, 0, 32'h4, 0, 0); req_b = 0; @(negedge clk); chk("mid_gnt_a1", gnt_a, 1); tick;
      reset = 0; bus(0, 0, 0, 0, 0); tick;
      reset = 1; bus(1, 0, 32'h8, 0, 0); req_b = 1; addr_b = 32'h4;
      @(negedge clk); chk("drop_rv_a", rv_a, 0); chk("drop_rv_b", rv_b, 0);
      chk("post_gnt_a", gnt_a, 1); chk("post_gnt_b", gnt_b, 1); tick;
      bus(0, 0, 0, 0, 0); req_b = 0;
      @(negedge clk); chk("post_rv_a", rv_a, 1); chk("post_rd_a", rd_a, NOP); chk("post_rv_b4", rv_b, 0); tick;
      @(negedge clk); chk("post_rv_a5", rv_a, 0); chk("post_rv_b5", rv_b, 0); tick;
      @(negedge clk); chk("post_rv_b6", rv_b, 1); chk("post_rd_b6", rd_b, 32'h00100113); tick;
      // continuous req after reset; periodic denial only when the stall feature is built in
      reset = 0; tick; reset = 1;
      prev_g = 0; n_g = 0; n_rv = 0;
      for (int c = 0; c < 12; c++) begin
         bus(1, 0, 32'h4, 0, 0);
         exp_g = STALL ? (c % 4 != 3) : 1'b1;
         @(negedge clk);
         chk($sformatf("cont_gnt%0d", c), gnt_a, exp_g);
         chk($sformatf("cont_rv%0d", c), rv_a, prev_g);
         n_g += int'(gnt_a); n_rv += int'(rv_a);
         tick;
         prev_g = exp_g;
      end
      bus(0, 0, 0, 0, 0);
      @(negedge clk); chk("cont_rv_last", rv_a, prev_g); n_rv += int'(rv_a); tick;
      @(negedge clk); chk("cont_rv_idle", rv_a, 0); chk("cont_balance", n_rv, n_g);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
